texv_stepper: RTL and testbench

Per-row texture V-coordinate generator for the wall renderer. Once per trace row, during blanking, it takes the row's wall `size`, runs an iterative divide and an optional multiply, then steps a fixed-point accumulator once per traced pixel. The result is the 6-bit `texv` consumed by `row_render` alongside `hpos`. It replaces a per-pixel divider with one sequential divide per row.

---
 rtl/texv_stepper.sv | 126 ++++++++++++
 tb/tb_texv_stepper.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/texv_stepper.sv
// Per-row texture V generator: one restoring divide (and an optional preset multiply)
// per row during blanking, then a fixed-point accumulator stepped once per traced pixel.
module texv_stepper #(
   parameter int H_VIEW = 640,
   parameter int FRAC   = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [10:0] size,
   input  logic [9:0]  hpos,
   input  logic        run,
   output logic [5:0]  texv,
   output logic        ready,
   output logic        busy
);

   localparam int HALF = H_VIEW / 2;
   localparam int SW   = FRAC + 6;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DIV   = 2'd1;
   localparam logic [1:0] S_MUL   = 2'd2;
   localparam logic [1:0] S_READY = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [10:0]       size_q, size_d;
   logic signed [11:0] top_q, top_d;
   logic [SW-1:0]     step_q, step_d;
   logic [SW-1:0]     acc_q, acc_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [10:0]       rem_q, rem_d;
   logic [10:0]       mul_q, mul_d;

   logic [11:0]       remShift;
   logic [10:0]       remSub;
   logic              qBit;
   logic [SW-1:0]     addend;

   // The only set dividend bit is the MSB of 2^(FRAC+5), shifted in on the first divide cycle.
   assign remShift = {rem_q, (cnt_q == 5'd0)};
   assign qBit     = (remShift >= {1'b0, size_q});
   assign remSub   = remShift[10:0] - size_q;
   assign addend   = mul_q[0] ? (step_q << cnt_q) : '0;

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      top_d   = top_q;
      step_d  = step_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      mul_d   = mul_q;
      if (load) begin
         size_d  = size;
         top_d   = 12'(HALF) - {1'b0, size};
         acc_d   = '0;
         step_d  = '0;
         cnt_d   = '0;
         rem_d   = '0;
         mul_d   = '0;
         state_d = (size == 11'd0) ? S_READY : S_DIV;
      end else begin
         case (state_q)
            S_DIV: begin
               rem_d  = qBit ? remSub : remShift[10:0];
               step_d = {step_q[SW-2:0], qBit};
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'(SW - 1)) begin
                  cnt_d = '0;
                  if (size_q > 11'(HALF)) begin
                     mul_d   = size_q - 11'(HALF);
                     state_d = S_MUL;
                  end else begin
                     state_d = S_READY;
                  end
               end
            end
            S_MUL: begin
               // Preset is the texv offset at hpos 0 when the wall top lies above the screen.
               acc_d = acc_q + addend;
               mul_d = mul_q >> 1;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd10) begin
                  cnt_d   = '0;
                  state_d = S_READY;
               end
            end
            S_READY: begin
               if (run && ($signed({2'b00, hpos}) >= top_q)) begin
                  acc_d = acc_q + step_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         size_q  <= '0;
         top_q   <= '0;
         step_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         mul_q   <= '0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         top_q   <= top_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         mul_q   <= mul_d;
      end
   end

   assign texv  = acc_q[FRAC+5:FRAC];
   assign ready = (state_q == S_READY);
   assign busy  = (state_q == S_DIV) || (state_q == S_MUL);

endmodule

// File: tb/tb_texv_stepper.sv
// Directed bench for texv_stepper: a vector table of {size, latency, hpos probe, texv}
// plus hand-written reset, abort and load/run collision sequences.
module tb_texv_stepper;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [10:0] size;
   logic [9:0]  hpos;
   logic        run;
   logic [5:0]  texv;
   logic        ready;
   logic        busy;

   int nCompared   = 0;
   int nMismatched = 0;

   texv_stepper #(.H_VIEW(640), .FRAC(10)) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .size  (size),
      .hpos  (hpos),
      .run   (run),
      .texv  (texv),
      .ready (ready),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] size;
      int          latency;
      int          probe;
      logic [5:0]  expTexv;
   } vecT;

   vecT vecs[17];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pulse load for one edge, then count edges until ready (bounded).
   task automatic applyStimulus(input logic [10:0] sz, output int lat);
      load = 1'b1;
      size = sz;
      tick();
      load = 1'b0;
      checkOutput($sformatf("busy_after_load_size%0d", sz), {31'd0, busy}, {31'd0, sz != 11'd0});
      lat = 0;
      while (!ready && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   // Trace hpos 0..probe-1 with run high, then present probe with run low.
   task automatic runTo(input int probe);
      for (int h = 0; h < probe; h++) begin
         hpos = 10'(h);
         run  = 1'b1;
         tick();
      end
      hpos = 10'(probe);
      run  = 1'b0;
      #1;
   endtask

   initial begin
      int lat;

      vecs[0]  = '{11'd32,   16, 288, 6'd0};
      vecs[1]  = '{11'd32,   16, 289, 6'd1};
      vecs[2]  = '{11'd32,   16, 351, 6'd63};
      vecs[3]  = '{11'd32,   16, 352, 6'd0};
      vecs[4]  = '{11'd320,  16, 10,  6'd0};
      vecs[5]  = '{11'd320,  16, 11,  6'd1};
      vecs[6]  = '{11'd320,  16, 639, 6'd63};
      vecs[7]  = '{11'd640,  27, 0,   6'd15};
      vecs[8]  = '{11'd640,  27, 2,   6'd16};
      vecs[9]  = '{11'd0,    0,  639, 6'd0};
      vecs[10] = '{11'd2047, 27, 0,   6'd26};
      vecs[11] = '{11'd2047, 27, 1,   6'd27};
      vecs[12] = '{11'd1,    16, 320, 6'd32};
      vecs[13] = '{11'd1,    16, 321, 6'd0};
      vecs[14] = '{11'd321,  27, 9,   6'd0};
      vecs[15] = '{11'd321,  27, 10,  6'd1};
      vecs[16] = '{11'd100,  16, 224, 6'd1};

      reset = 1'b1;
      load  = 1'b0;
      run   = 1'b0;
      size  = '0;
      hpos  = '0;

      for (int i = 0; i < 4; i++) begin
         run  = ~run;
         hpos = hpos + 10'd1;
         tick();
         checkOutput($sformatf("reset_texv_%0d", i), {26'd0, texv}, 32'd0);
         checkOutput($sformatf("reset_ready_%0d", i), {31'd0, ready}, 32'd0);
         checkOutput($sformatf("reset_busy_%0d", i), {31'd0, busy}, 32'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run  = ~run;
         hpos = hpos + 10'd1;
         tick();
         checkOutput($sformatf("idle_texv_%0d", i), {26'd0, texv}, 32'd0);
         checkOutput($sformatf("idle_ready_%0d", i), {31'd0, ready}, 32'd0);
      end
      run  = 1'b0;
      hpos = '0;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].size, lat);
         checkOutput($sformatf("vec%0d_latency_size%0d", i, vecs[i].size), 32'(lat), 32'(vecs[i].latency));
         checkOutput($sformatf("vec%0d_busy_at_ready", i), {31'd0, busy}, 32'd0);
         runTo(vecs[i].probe);
         checkOutput($sformatf("vec%0d_texv_size%0d_h%0d", i, vecs[i].size, vecs[i].probe),
                     {26'd0, texv}, {26'd0, vecs[i].expTexv});
      end

      // Abort: second load 7 edges into a divide restarts with the new size.
      hpos = '0;
      load = 1'b1;
      size = 11'd100;
      tick();
      load = 1'b0;
      repeat (7) tick();
      checkOutput("abort_busy_mid_div", {31'd0, busy}, 32'd1);
      applyStimulus(11'd32, lat);
      checkOutput("abort_latency", 32'(lat), 32'd16);
      runTo(289);
      checkOutput("abort_texv_h289", {26'd0, texv}, 32'd1);

      // load and run together in READY: load wins, acc cleared, run during divide ignored.
      hpos = 10'd300;
      run  = 1'b1;
      load = 1'b1;
      size = 11'd320;
      tick();
      load = 1'b0;
      checkOutput("collide_texv", {26'd0, texv}, 32'd0);
      checkOutput("collide_ready", {31'd0, ready}, 32'd0);
      checkOutput("collide_busy", {31'd0, busy}, 32'd1);
      hpos = 10'd400;
      lat  = 0;
      while (!ready && lat < 40) begin
         tick();
         lat++;
      end
      run = 1'b0;
      checkOutput("collide_latency", 32'(lat), 32'd16);
      checkOutput("collide_texv_at_ready", {26'd0, texv}, 32'd0);

      // Reset asserted in READY clears outputs immediately and nothing resumes.
      hpos = '0;
      applyStimulus(11'd640, lat);
      checkOutput("rst_ready_latency", 32'(lat), 32'd27);
      checkOutput("rst_preset_texv", {26'd0, texv}, 32'd15);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_async_texv", {26'd0, texv}, 32'd0);
      checkOutput("rst_async_ready", {31'd0, ready}, 32'd0);
      checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
      tick();
      reset = 1'b0;
      run   = 1'b1;
      hpos  = 10'd5;
      tick();
      tick();
      run = 1'b0;
      checkOutput("post_rst_ready", {31'd0, ready}, 32'd0);
      checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("post_rst_texv", {26'd0, texv}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
